// File: rtl/qam_frame_sequencer.sv
// Frame sequencer for the QAM demapper symbol FIFO: clear, capture one frame, host readout, done.
// Optional capture watchdog built when QAM_SEQ_WATCHDOG_EN is defined.
module qam_frame_sequencer #(
    parameter int DEPTH_LOG2 = 6,
    parameter int TIMEOUT    = 1023
) (
    input  logic                  dclk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  sym_valid,
    input  logic                  fifo_wfull,
    input  logic                  fifo_rdempty,
    input  logic                  host_rd_req,
    output logic                  fifo_wr_en,
    output logic                  fifo_rd_en,
    output logic                  fifo_aclr,
    output logic                  host_rd_ack,
    output logic                  available,
    output logic                  complete,
    output logic                  busy,
    output logic [DEPTH_LOG2:0]   sym_count,
    output logic                  overflow,
    output logic                  timeout_err
);
    localparam int CW = DEPTH_LOG2 + 1;
    localparam logic [CW-1:0] FRAME_LEN  = CW'(1 << DEPTH_LOG2);
    localparam logic [CW-1:0] FRAME_LAST = CW'((1 << DEPTH_LOG2) - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_CAPTURE, S_READY, S_READOUT, S_DONE
    } state_t;

    state_t        state, state_nxt;
    logic          abort_pend;
    logic [CW-1:0] rd_remaining;
    logic          wd_expire;

`ifdef QAM_SEQ_WATCHDOG_EN
    logic [15:0] wd_cnt;

    assign wd_expire = (state == S_CAPTURE) && !sym_valid && (wd_cnt == 16'(TIMEOUT - 1));

    always_ff @(posedge dclk or posedge reset) begin
        if (reset) begin
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
        end else if (state == S_CLEAR) begin
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
        end else if (state == S_CAPTURE) begin
            wd_cnt <= sym_valid ? 16'd0 : wd_cnt + 16'd1;
            if (wd_expire)
                timeout_err <= 1'b1;
        end
    end
`else
    // TIMEOUT only matters when the watchdog is built.
    logic [31:0] unused_timeout;
    assign unused_timeout = 32'(TIMEOUT);
    assign wd_expire      = 1'b0;
    assign timeout_err    = 1'b0;
`endif

    always_comb begin
        state_nxt  = state;
        fifo_wr_en = 1'b0;
        fifo_rd_en = 1'b0;
        case (state)
            S_IDLE:
                if (start && !abort) state_nxt = S_CLEAR;
            S_CLEAR:
                state_nxt = (abort_pend || abort) ? S_IDLE : S_CAPTURE;
            S_CAPTURE: begin
                fifo_wr_en = sym_valid && !fifo_wfull && (sym_count < FRAME_LEN);
                if (abort)
                    state_nxt = S_CLEAR;
                else if ((fifo_wr_en && sym_count == FRAME_LAST) ||
                         (fifo_wfull && sym_count != '0))
                    state_nxt = S_READY;
                else if (wd_expire)
                    state_nxt = (sym_count != '0) ? S_READY : S_IDLE;
            end
            S_READY:
                if (abort)            state_nxt = S_CLEAR;
                else if (host_rd_req) state_nxt = S_READOUT;
            S_READOUT: begin
                fifo_rd_en = host_rd_req && !fifo_rdempty && (rd_remaining != '0);
                if (abort)
                    state_nxt = S_CLEAR;
                else if ((fifo_rd_en && rd_remaining == CW'(1)) || fifo_rdempty)
                    state_nxt = S_DONE;
            end
            S_DONE:
                state_nxt = abort ? S_CLEAR : S_IDLE;
            default:
                state_nxt = S_IDLE;
        endcase
    end

    assign available = (state == S_READY) || (state == S_READOUT);
    assign complete  = (state == S_DONE);
    assign busy      = (state != S_IDLE);

    always_ff @(posedge dclk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            abort_pend  <= 1'b0;
            fifo_aclr   <= 1'b0;
            host_rd_ack <= 1'b0;
        end else begin
            state       <= state_nxt;
            // Entering CLEAR from anywhere but IDLE can only be an abort.
            abort_pend  <= (state_nxt == S_CLEAR) && (state != S_IDLE);
            fifo_aclr   <= (state_nxt == S_CLEAR);
            host_rd_ack <= fifo_rd_en;
        end
    end

    always_ff @(posedge dclk or posedge reset) begin
        if (reset) begin
            sym_count    <= '0;
            rd_remaining <= '0;
            overflow     <= 1'b0;
        end else begin
            case (state)
                S_CLEAR: begin
                    sym_count    <= '0;
                    rd_remaining <= '0;
                    overflow     <= 1'b0;
                end
                S_CAPTURE: begin
                    if (fifo_wr_en)             sym_count <= sym_count + CW'(1);
                    if (sym_valid && fifo_wfull) overflow  <= 1'b1;
                end
                S_READY:
                    rd_remaining <= sym_count;
                S_READOUT:
                    if (fifo_rd_en) rd_remaining <= rd_remaining - CW'(1);
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_qam_frame_sequencer.sv
// Directed bench for qam_frame_sequencer: vector table for the overflow frame plus hand sequences.
module tb_qam_frame_sequencer;
    logic dclk = 1'b0;
    logic reset, start, abort, sym_valid, fifo_wfull, fifo_rdempty, host_rd_req;
    logic fifo_wr_en, fifo_rd_en, fifo_aclr, host_rd_ack, available, complete, busy;
    logic [6:0] sym_count;
    logic overflow, timeout_err;

    int n_checks = 0;
    int n_err    = 0;

    qam_frame_sequencer #(.DEPTH_LOG2(6), .TIMEOUT(16)) dut (
        .dclk(dclk), .reset(reset), .start(start), .abort(abort),
        .sym_valid(sym_valid), .fifo_wfull(fifo_wfull), .fifo_rdempty(fifo_rdempty),
        .host_rd_req(host_rd_req), .fifo_wr_en(fifo_wr_en), .fifo_rd_en(fifo_rd_en),
        .fifo_aclr(fifo_aclr), .host_rd_ack(host_rd_ack), .available(available),
        .complete(complete), .busy(busy), .sym_count(sym_count),
        .overflow(overflow), .timeout_err(timeout_err)
    );

    always #5 dclk = ~dclk;

    typedef struct {
        logic s, a, sv, wf, re, rq;
        logic wr, rd, acl, ack, av, cp, bz;
        int   cnt;
        logic ovf;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(logic s, logic a, logic sv, logic wf, logic re, logic rq,
                               logic wr, logic rd, logic acl, logic ack, logic av, logic cp,
                               logic bz, int cnt, logic ovf);
        vec_t t;
        t.s = s; t.a = a; t.sv = sv; t.wf = wf; t.re = re; t.rq = rq;
        t.wr = wr; t.rd = rd; t.acl = acl; t.ack = ack; t.av = av; t.cp = cp; t.bz = bz;
        t.cnt = cnt; t.ovf = ovf;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge dclk);
        #2;
    endtask

    function automatic logic [15:0] outs();
        return {fifo_wr_en, fifo_rd_en, fifo_aclr, host_rd_ack, available, complete, busy,
                overflow, timeout_err, sym_count};
    endfunction

    // Start a frame, write n symbols, then end capture with fifo_wfull; leaves the block in READY.
    task automatic short_frame(input int n);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        sym_valid = 1'b1;
        repeat (n) step();
        sym_valid  = 1'b0;
        fifo_wfull = 1'b1;
        step();
        fifo_wfull = 1'b0;
        #1;
        check("short_frame_available", available, 1);
        check("short_frame_count", sym_count, n);
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int wr_n, aclr_n, rd_n, ack_n, comp_n, av_n;
        int last_rd, comp_c, idle_c, comp_ack;
        int reads_done, rd_bad, ack_bad;
        logic prev_rd, exp_rd;

        reset = 1'b1; start = 0; abort = 0; sym_valid = 0;
        fifo_wfull = 0; fifo_rdempty = 0; host_rd_req = 0;
        #3;
        check("reset_outputs", {16'h0, outs()}, 32'h0);
        #9 reset = 1'b0;
        step();

        // Overflow frame: 10 writes, wfull with sym_valid held, readout of 10 words.
        tbl.push_back(v(1,0,0,0,0,0, 0,0,0,0,0,0,0, 0,0));
        tbl.push_back(v(0,0,0,0,0,0, 0,0,1,0,0,0,1, 0,0));
        for (int k = 0; k < 10; k++)
            tbl.push_back(v(0,0,1,0,0,0, 1,0,0,0,0,0,1, k,0));
        tbl.push_back(v(0,0,1,1,0,0, 0,0,0,0,0,0,1, 10,0));
        tbl.push_back(v(0,0,1,1,0,0, 0,0,0,0,1,0,1, 10,1));
        tbl.push_back(v(0,0,0,0,0,1, 0,0,0,0,1,0,1, 10,1));
        for (int k = 0; k < 10; k++)
            tbl.push_back(v(0,0,0,0,0,1, 0,1,0,(k > 0),1,0,1, 10,1));
        tbl.push_back(v(0,0,0,0,0,1, 0,0,0,1,0,1,1, 10,1));
        tbl.push_back(v(0,0,0,0,0,0, 0,0,0,0,0,0,0, 10,1));

        for (int i = 0; i < tbl.size(); i++) begin
            start = tbl[i].s; abort = tbl[i].a; sym_valid = tbl[i].sv;
            fifo_wfull = tbl[i].wf; fifo_rdempty = tbl[i].re; host_rd_req = tbl[i].rq;
            #1;
            check($sformatf("vec%0d", i), {16'h0, outs()},
                  {16'h0, tbl[i].wr, tbl[i].rd, tbl[i].acl, tbl[i].ack, tbl[i].av, tbl[i].cp,
                   tbl[i].bz, tbl[i].ovf, 1'b0, 7'(tbl[i].cnt)});
            step();
        end
        start = 0; sym_valid = 0; fifo_wfull = 0; host_rd_req = 0;

        // Full 64-symbol frame with sym_valid held high.
        wr_n = 0; aclr_n = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        sym_valid = 1'b1;
        for (int c = 0; c < 200; c++) begin
            #1;
            if (available) break;
            wr_n += int'(fifo_wr_en);
            aclr_n += int'(fifo_aclr);
            step();
        end
        sym_valid = 1'b0;
        check("full_aclr_pulses", aclr_n, 1);
        check("full_writes", wr_n, 64);
        check("full_count", sym_count, 64);
        check("full_available", available, 1);
        check("full_overflow_cleared", overflow, 0);

        rd_n = 0; ack_n = 0; comp_n = 0; last_rd = -1; comp_c = -1; idle_c = -1; comp_ack = 0;
        host_rd_req = 1'b1;
        for (int c = 0; c < 200; c++) begin
            #1;
            if (fifo_rd_en) begin rd_n++; last_rd = c; end
            if (host_rd_ack) ack_n++;
            if (complete) begin comp_n++; comp_c = c; comp_ack = int'(host_rd_ack); end
            if (!busy) begin idle_c = c; break; end
            step();
        end
        host_rd_req = 1'b0;
        check("full_reads", rd_n, 64);
        check("full_acks", ack_n, 64);
        check("full_last_read_cycle", last_rd, 64);
        check("full_complete_count", comp_n, 1);
        check("full_complete_cycle", comp_c, 65);
        check("full_ack_with_complete", comp_ack, 1);
        check("full_idle_cycle", idle_c, 66);
        check("full_count_held", sym_count, 64);
        step();

        // Abort after 20 symbols: one clear pulse, back to IDLE, no available/complete.
        wr_n = 0; aclr_n = 0; av_n = 0; comp_n = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        sym_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            #1;
            wr_n += int'(fifo_wr_en);
            av_n += int'(available);
            step();
        end
        sym_valid = 1'b0;
        abort = 1'b1;
        #1;
        check("abort_capture_count", sym_count, 20);
        step();
        abort = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            aclr_n += int'(fifo_aclr);
            av_n += int'(available);
            comp_n += int'(complete);
            step();
        end
        check("abort_writes", wr_n, 20);
        check("abort_aclr_pulses", aclr_n, 1);
        check("abort_no_available", av_n, 0);
        check("abort_no_complete", comp_n, 0);
        check("abort_idle", busy, 0);
        check("abort_count_cleared", sym_count, 0);

        start = 1'b1; abort = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        #1;
        check("start_abort_idle", {busy, fifo_aclr}, 0);
        step();

        // Abort while in CLEAR after a normal start.
        start = 1'b1;
        step();
        start = 1'b0; abort = 1'b1;
        #1;
        check("clear_state_aclr", fifo_aclr, 1);
        step();
        abort = 1'b0;
        #1;
        check("clear_abort_idle", busy, 0);
        step();

        // Host stall: request pattern 1,0,0 repeating.
        short_frame(6);
        host_rd_req = 1'b1;
        step();
        reads_done = 0; rd_bad = 0; ack_bad = 0; ack_n = 0; prev_rd = 1'b0; idle_c = -1;
        for (int c = 0; c < 60; c++) begin
            host_rd_req = (c % 3 == 0);
            #1;
            exp_rd = host_rd_req && (reads_done < 6);
            if (fifo_rd_en !== exp_rd) rd_bad++;
            if (host_rd_ack !== prev_rd) ack_bad++;
            if (host_rd_ack) ack_n++;
            if (exp_rd) reads_done++;
            prev_rd = fifo_rd_en;
            if (!busy) begin idle_c = c; break; end
            step();
        end
        host_rd_req = 1'b0;
        check("stall_rd_pattern_errs", rd_bad, 0);
        check("stall_ack_delay_errs", ack_bad, 0);
        check("stall_acks", ack_n, 6);
        check("stall_reached_idle", idle_c >= 0, 1);
        step();

        // FIFO empties early during readout.
        short_frame(4);
        host_rd_req = 1'b1;
        step();
        step();
        step();
        fifo_rdempty = 1'b1;
        #1;
        check("early_empty_no_read", fifo_rd_en, 0);
        step();
        #1;
        check("early_empty_done", {complete, available}, 2'b10);
        step();
        #1;
        check("early_empty_idle", busy, 0);
        fifo_rdempty = 1'b0; host_rd_req = 1'b0;
        step();

        // Asynchronous reset between edges in READOUT.
        short_frame(8);
        host_rd_req = 1'b1;
        step();
        step();
        #2 reset = 1'b1;
        #1;
        check("async_reset_outputs", {16'h0, outs()}, 32'h0);
        #1 reset = 1'b0;
        host_rd_req = 1'b0;
        step();
        short_frame(3);
        host_rd_req = 1'b1;
        ack_n = 0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (host_rd_ack) ack_n++;
            if (!busy) break;
            step();
        end
        host_rd_req = 1'b0;
        check("after_reset_acks", ack_n, 3);
        check("after_reset_idle", busy, 0);
        step();

        // Capture silence: watchdog behaviour depends on the build.
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        sym_valid = 1'b1;
        repeat (5) step();
        sym_valid = 1'b0;
`ifdef QAM_SEQ_WATCHDOG_EN
        repeat (15) step();
        #1;
        check("wd_not_yet", {available, timeout_err}, 2'b00);
        step();
        #1;
        check("wd_partial_ready", {available, timeout_err, sym_count}, {2'b11, 7'd5});
        abort = 1'b1;
        step();
        abort = 1'b0;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        av_n = 0;
        for (int c = 0; c < 16; c++) begin
            #1;
            av_n += int'(available);
            step();
        end
        #1;
        check("wd_empty_idle", {busy, timeout_err}, 2'b01);
        check("wd_empty_no_available", av_n, 0);
`else
        repeat (40) step();
        #1;
        check("no_wd_waits", {busy, available, timeout_err, sym_count}, {3'b100, 7'd5});
        abort = 1'b1;
        step();
        abort = 1'b0;
        step();
        #1;
        check("no_wd_abort_idle", busy, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
